// File: rtl/om_score_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : om_score_writer_pkg
//  Purpose  : Shared constants for the OM score map: address/score widths,
//             default map geometry (shared with the max-value search) and
//             the writer FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package om_score_writer_pkg;

    localparam int OM_ADDR_W = 13;
    localparam int SCORE_W   = 32;

    // Default score-map geometry; the max-value search uses the same values.
    localparam int DEF_MAP_W = 80;
    localparam int DEF_MAP_H = 60;

    // Writer FSM encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_WAIT_MV = 2'd3;

    // Negative scores carry no useful peak information; optionally floor them at 0.
    function automatic logic [SCORE_W-1:0] clamp_score(
        input logic [SCORE_W-1:0] score,
        input logic               clamp_en
    );
        return (clamp_en && score[SCORE_W-1]) ? '0 : score;
    endfunction

endpackage
`default_nettype wire

// File: rtl/om_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module   : om_raster_counter
//  Purpose  : Raster-order col/row/linear-address counters for the OM map.
//             Address is advanced incrementally so no multiplier is needed.
//             Counters stop at the last map position (no wrap in a frame).
//  Revision : 1.0  initial release
// ============================================================================
module om_raster_counter
    import om_score_writer_pkg::*;
#(
    parameter int MAP_W  = DEF_MAP_W,
    parameter int MAP_H  = DEF_MAP_H,
    parameter int ADDR_W = OM_ADDR_W
)(
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int COL_W = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int ROW_W = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAP_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAP_H - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign last = (col == LAST_COL) && (row == LAST_ROW);

    // Advance col/row/address on each enabled step; clear has priority.
    always_ff @(posedge iClk) begin
        if (!iReset_n || clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (en && !last) begin
            addr <= addr + 1'b1;
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/om_score_writer.sv
`default_nettype none
// ============================================================================
//  Module   : om_score_writer
//  Purpose  : Writes a raster stream of classifier scores into OM, kicks the
//             max-value search when the map is complete, and holds off new
//             frames until that search releases OM.
//  Revision : 1.0  initial release
// ============================================================================
module om_score_writer
    import om_score_writer_pkg::*;
#(
    parameter int MAP_W     = DEF_MAP_W,
    parameter int MAP_H     = DEF_MAP_H,
    parameter int CLAMP_NEG = 1
)(
    input  logic                 iClk,
    input  logic                 iReset_n,
    input  logic                 iStart,
    input  logic                 iAbort,
    input  logic                 iValid,
    input  logic [SCORE_W-1:0]   iScore,
    output logic                 oReady,
    output logic                 oWr_OM,
    output logic [OM_ADDR_W-1:0] oAddr_OM,
    output logic [SCORE_W-1:0]   oData_OM,
    output logic                 oRun_MV,
    input  logic                 iMV_end,
    output logic                 oBusy,
    output logic [OM_ADDR_W-1:0] oCount
);

    localparam int               TOTAL   = MAP_W * MAP_H;
    localparam int               CNT_W   = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TOTAL);

    logic [1:0]           state;
    logic [1:0]           next_state;
    logic [OM_ADDR_W-1:0] cur_addr;
    logic                 at_last;
    logic                 accept;
    logic                 clr;
    logic                 mv_end_seen;
    logic [CNT_W-1:0]     count;

    assign oReady = (state == ST_WRITE);
    assign oBusy  = (state != ST_IDLE);
    assign accept = oReady && iValid;
    assign clr    = iAbort || ((state == ST_IDLE) && iStart);
    assign oCount = OM_ADDR_W'(count);

    om_raster_counter #(
        .MAP_W  (MAP_W),
        .MAP_H  (MAP_H),
        .ADDR_W (OM_ADDR_W)
    ) u_raster (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .clr      (clr),
        .en       (accept),
        .addr     (cur_addr),
        .last     (at_last)
    );

    // Next-state selection; abort overrides every transition.
    always_comb begin
        next_state = state;
        if (iAbort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (iStart)                 next_state = ST_WRITE;
                ST_WRITE:   if (accept && at_last)      next_state = ST_DONE;
                ST_DONE:                                next_state = ST_WAIT_MV;
                ST_WAIT_MV: if (iMV_end || mv_end_seen) next_state = ST_IDLE;
                default:                                next_state = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge iClk) begin
        if (!iReset_n) state <= ST_IDLE;
        else           state <= next_state;
    end

    // Remember an end pulse that lands in the DONE cycle so WAIT_MV exits at once.
    always_ff @(posedge iClk) begin
        if (!iReset_n || iAbort)                  mv_end_seen <= 1'b0;
        else if ((state == ST_DONE) && iMV_end)   mv_end_seen <= 1'b1;
        else if (state != ST_DONE)                mv_end_seen <= 1'b0;
    end

    // Registered OM write port; address/data hold between strobes.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            oWr_OM   <= 1'b0;
            oAddr_OM <= '0;
            oData_OM <= '0;
        end else begin
            oWr_OM <= accept;
            if (accept) begin
                oAddr_OM <= cur_addr;
                oData_OM <= clamp_score(iScore, CLAMP_NEG != 0);
            end
        end
    end

    // Search start follows DONE by one cycle, i.e. after the final OM write lands.
    always_ff @(posedge iClk) begin
        if (!iReset_n) oRun_MV <= 1'b0;
        else           oRun_MV <= (state == ST_DONE) && !iAbort;
    end

    // Accepted-score count for the current frame, saturating at the map size.
    always_ff @(posedge iClk) begin
        if (!iReset_n || clr)                  count <= '0;
        else if (accept && (count != CNT_MAX)) count <= count + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_om_score_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_om_score_writer
//  Purpose  : Directed self-checking bench for om_score_writer on a 4x3 map,
//             with clamping enabled (u_dut0) and disabled (u_dut1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_om_score_writer;

    localparam int MW = 4;
    localparam int MH = 3;
    localparam int N  = MW * MH;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic        valid  = 1'b0;
    logic        mv_end = 1'b0;
    logic [31:0] score  = '0;

    logic        ready0, wr0, run0, busy0;
    logic [12:0] addr0, count0;
    logic [31:0] data0;
    logic        ready1, wr1, run1, busy1;
    logic [12:0] addr1, count1;
    logic [31:0] data1;

    om_score_writer #(.MAP_W(MW), .MAP_H(MH), .CLAMP_NEG(1)) u_dut0 (
        .iClk(clk), .iReset_n(rst_n), .iStart(start), .iAbort(abort),
        .iValid(valid), .iScore(score), .oReady(ready0), .oWr_OM(wr0),
        .oAddr_OM(addr0), .oData_OM(data0), .oRun_MV(run0), .iMV_end(mv_end),
        .oBusy(busy0), .oCount(count0)
    );

    om_score_writer #(.MAP_W(MW), .MAP_H(MH), .CLAMP_NEG(0)) u_dut1 (
        .iClk(clk), .iReset_n(rst_n), .iStart(start), .iAbort(abort),
        .iValid(valid), .iScore(score), .oReady(ready1), .oWr_OM(wr1),
        .oAddr_OM(addr1), .oData_OM(data1), .oRun_MV(run1), .iMV_end(mv_end),
        .oBusy(busy1), .oCount(count1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/run log, sampled mid-cycle
    logic [12:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] q_raw[$];
    int          q_cyc[$];
    int          n_run  = 0;
    int          run_cyc = 0;

    always @(negedge clk) begin
        if (wr0) begin
            q_addr.push_back(addr0);
            q_data.push_back(data0);
            q_raw.push_back(data1);
            q_cyc.push_back(cyc);
        end
        if (run0) begin
            n_run   = n_run + 1;
            run_cyc = cyc;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    int          exp_cyc[N];
    logic [31:0] vals[N];
    int          wb;
    int          rb;
    int          acc;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        tick(); tick();
        check("rst_ready", ready0, 0);
        check("rst_wr",    wr0,    0);
        check("rst_addr",  addr0,  0);
        check("rst_data",  data0,  0);
        check("rst_run",   run0,   0);
        check("rst_busy",  busy0,  0);
        check("rst_count", count0, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- back-to-back frame ----------------
        wb = q_addr.size(); rb = n_run;
        pulse_start();
        check("b2b_busy",  busy0,  1);
        check("b2b_ready", ready0, 1);
        for (int i = 0; i < N; i++) begin
            valid = 1'b1; score = 32'(i + 1); exp_cyc[i] = cyc + 1;
            tick();
        end
        valid = 1'b0;
        check("b2b_ready_drop", ready0, 0);
        tick(); tick(); tick();
        check("b2b_nwr", q_addr.size() - wb, N);
        for (int i = 0; i < N; i++) begin
            check($sformatf("b2b_addr%0d", i), q_addr[wb+i], i);
            check($sformatf("b2b_data%0d", i), q_data[wb+i], i + 1);
            check($sformatf("b2b_cyc%0d",  i), q_cyc[wb+i],  exp_cyc[i]);
        end
        check("b2b_nrun",   n_run - rb, 1);
        check("b2b_runcyc", run_cyc, exp_cyc[N-1] + 1);
        check("b2b_count",  count0, N);

        // ---------------- blocked while waiting for search ----------------
        wb = q_addr.size();
        repeat (50) tick();
        start = 1'b1; valid = 1'b1; score = 32'd99;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("blk_ready", ready0, 0);
        check("blk_busy",  busy0,  1);
        check("blk_nwr",   q_addr.size() - wb, 0);
        valid = 1'b0;
        mv_end = 1'b1;
        tick();
        mv_end = 1'b0;
        check("blk_release_busy", busy0, 0);

        // ---------------- stalled frame, restart at 0 ----------------
        wb = q_addr.size(); rb = n_run; acc = 0;
        pulse_start();
        for (int k = 0; k < 100 && acc < N; k++) begin
            valid = ((k % 4) == 0) || ((k % 4) == 3);
            score = 32'(100 + acc);
            if (valid) begin
                exp_cyc[acc] = cyc + 1;
                acc++;
            end
            tick();
        end
        valid = 1'b0;
        tick(); tick(); tick();
        check("stl_nwr", q_addr.size() - wb, N);
        for (int i = 0; i < N; i++) begin
            check($sformatf("stl_addr%0d", i), q_addr[wb+i], i);
            check($sformatf("stl_data%0d", i), q_data[wb+i], 100 + i);
            check($sformatf("stl_cyc%0d",  i), q_cyc[wb+i],  exp_cyc[i]);
        end
        check("stl_count", count0, N);
        check("stl_nrun",  n_run - rb, 1);
        mv_end = 1'b1; tick(); mv_end = 1'b0; tick();

        // ---------------- clamp, and end pulse in DONE cycle ----------------
        vals[0] = 32'h8000_0005; vals[1] = 32'h7FFF_FFFF; vals[2] = 32'hFFFF_FFFF;
        vals[3] = 32'h0000_0000; vals[4] = 32'h8000_0000;
        for (int i = 5; i < N; i++) vals[i] = 32'(i);
        wb = q_addr.size(); rb = n_run;
        pulse_start();
        for (int i = 0; i < N; i++) begin
            valid = 1'b1; score = vals[i];
            tick();
        end
        valid = 1'b0;
        mv_end = 1'b1;      // state is DONE here
        tick();
        mv_end = 1'b0;
        check("stk_busy_wait", busy0, 1);
        tick();
        check("stk_busy_idle", busy0, 0);
        check("stk_nrun", n_run - rb, 1);
        check("clp_d0_c", q_data[wb+0], 32'h0000_0000);
        check("clp_d1_c", q_data[wb+1], 32'h7FFF_FFFF);
        check("clp_d2_c", q_data[wb+2], 32'h0000_0000);
        check("clp_d4_c", q_data[wb+4], 32'h0000_0000);
        check("clp_d5_c", q_data[wb+5], 32'd5);
        check("clp_d0_r", q_raw[wb+0],  32'h8000_0005);
        check("clp_d1_r", q_raw[wb+1],  32'h7FFF_FFFF);
        check("clp_d2_r", q_raw[wb+2],  32'hFFFF_FFFF);
        check("clp_d4_r", q_raw[wb+4],  32'h8000_0000);

        // ---------------- abort after 5 scores ----------------
        wb = q_addr.size(); rb = n_run;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; score = 32'(200 + i);
            tick();
        end
        valid = 1'b0;
        check("abt_count5", count0, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abt_busy",  busy0,  0);
        check("abt_ready", ready0, 0);
        check("abt_count", count0, 0);
        repeat (4) tick();
        check("abt_nwr",  q_addr.size() - wb, 5);
        check("abt_nrun", n_run - rb, 0);
        pulse_start();
        valid = 1'b1; score = 32'd300;
        tick();
        valid = 1'b0;
        tick();
        check("abt_new_addr", q_addr[q_addr.size()-1], 0);
        check("abt_new_data", q_data[q_data.size()-1], 300);
        abort = 1'b1; tick(); abort = 1'b0; tick();

        // ---------------- abort together with final acceptance ----------------
        wb = q_addr.size(); rb = n_run;
        pulse_start();
        for (int i = 0; i < N; i++) begin
            valid = 1'b1; score = 32'(400 + i);
            abort = (i == N - 1);
            tick();
        end
        valid = 1'b0; abort = 1'b0;
        check("abl_busy", busy0, 0);
        repeat (4) tick();
        check("abl_nwr",   q_addr.size() - wb, N);
        check("abl_laddr", q_addr[q_addr.size()-1], N - 1);
        check("abl_ldata", q_data[q_data.size()-1], 400 + N - 1);
        check("abl_nrun",  n_run - rb, 0);

        // ---------------- reset mid-frame ----------------
        wb = q_addr.size();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; score = 32'(500 + i);
            tick();
        end
        score = 32'd555;
        rst_n = 1'b0;
        tick();
        check("mrst_wr",    wr0,    0);
        check("mrst_addr",  addr0,  0);
        check("mrst_data",  data0,  0);
        check("mrst_ready", ready0, 0);
        check("mrst_busy",  busy0,  0);
        check("mrst_count", count0, 0);
        check("mrst_run",   run0,   0);
        rst_n = 1'b1;
        repeat (3) tick();
        valid = 1'b0;
        tick();
        check("mrst_nwr", q_addr.size() - wb, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/om_score_writer.md
Name: om_score_writer

Overview:
Producer side of the output-memory (OM) score map that the 19x19 max-value search consumes. Accepts a raster-ordered stream of 32-bit window scores from the classifier and writes them into OM at 13-bit addresses, row*MAP_W+col. When the last score of a frame is written, it pulses the max-value search start. It then blocks new frames until that search reports end, so OM is never overwritten while being read.

Parameters:
MAP_W, 80, score-map width in window positions (columns)
MAP_H, 60, score-map height (rows); MAP_W*MAP_H must be <= 8192
CLAMP_NEG, 1, if 1 treat iScore as signed and write negative scores as 0

Ports:
iClk  in  1  clock
iReset_n  in  1  reset, synchronous, active-low
iStart  in  1  one-cycle pulse: begin accepting a new frame
iAbort  in  1  drop current frame and return to IDLE
iValid  in  1  iScore valid this cycle
iScore  in  32  classifier score for the next raster position
oReady  out  1  writer accepts a score this cycle
oWr_OM  out  1  OM write strobe
oAddr_OM  out  13  OM write address
oData_OM  out  32  OM write data
oRun_MV  out  1  one-cycle pulse: score map complete, start max-value search
iMV_end  in  1  max-value/threshold chain finished with OM (its end pulse)
oBusy  out  1  high in any state except IDLE
oCount  out  13  number of scores written in current frame

Behaviour:
- Reset values: all outputs 0; state IDLE; col, row and address counters 0.
- FSM states:
  - IDLE: oReady=0. iStart moves to WRITE and clears counters. iStart in any other state is ignored.
  - WRITE: oReady=1. A score is accepted on iValid&&oReady. A cycle with iValid=0 is a stall; counters hold and nothing is written.
  - On acceptance of the MAP_W*MAP_H-th score: move to DONE; oReady drops the next cycle.
  - DONE: one cycle. oRun_MV=1. Then move to WAIT_MV.
  - WAIT_MV: oReady=0. Wait for iMV_end, then go to IDLE.
- Write latency: 1 cycle, registered.
  - Acceptance in cycle t gives oWr_OM=1 in cycle t+1, with oAddr_OM = current address and oData_OM = processed score.
  - oAddr_OM/oData_OM hold their last values when oWr_OM=0.
- oRun_MV is asserted in the cycle after the final oWr_OM strobe, so OM already holds the full map.
- Addressing is incremental (no multiplier).
  - col increments on each accepted score.
  - When col==MAP_W-1: col goes to 0 and row increments.
  - The address increments by 1 on every accepted score.
  - Address 0 is written first; the last address is MAP_W*MAP_H-1. No wrap within a frame.
- Clamp: if CLAMP_NEG=1 and iScore[31]=1, oData_OM=0; otherwise oData_OM=iScore.
- oCount equals the number of accepted scores in the current frame. It saturates at MAP_W*MAP_H and clears on the next iStart.
- iAbort:
  - Has priority over all else in any state; next state is IDLE, counters clear.
  - A write already registered from the previous cycle still completes.
  - oRun_MV is not issued.
  - iAbort in the same cycle as the final acceptance: the score is written, but there is no DONE and no oRun_MV.
- iMV_end is ignored outside WAIT_MV. iMV_end arriving in the DONE cycle is held (sticky), and the FSM goes WAIT_MV -> IDLE immediately.
- Reset mid-frame: everything returns to reset values on the next edge, and any pending write is dropped.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/WRITE/DONE/WAIT_MV)
  - OM_ADDR_W=13
  - SCORE_W=32
  - the default MAP_W/MAP_H constants (shared with the max-value search so both ends agree on map geometry)
- One natural sub-module: om_raster_counter (col/row/address counters with clear, enable and last-position flag). Reusable by the OM reader side.

Test Plan:
- Small map (MAP_W=4, MAP_H=3), iStart then 12 back-to-back valid scores 1..12 -> oWr_OM on 12 consecutive cycles, addresses 0..11 with data 1..11,12. oRun_MV pulses exactly once, one cycle after the address-11 write. oReady=0 afterwards.
- Same map, iValid toggled 1,0,0,1 pattern -> no writes in stall cycles. Addresses remain contiguous. oCount=12 at end.
- CLAMP_NEG=1 with scores 0x80000005, 0x7FFFFFFF -> OM data 0x00000000, 0x7FFFFFFF. CLAMP_NEG=0 -> raw values written.
- After oRun_MV, hold iMV_end low 50 cycles, pulse iStart and drive iValid -> no oWr_OM, oReady=0, oBusy=1. Pulse iMV_end -> IDLE. The next iStart restarts at address 0.
- iAbort after 5 accepted scores -> 5 writes total, no oRun_MV, oBusy=0 the next cycle. A new frame writes from address 0.
- iReset_n low for 1 cycle mid-WRITE -> all outputs 0 next cycle, no further writes until iStart.
